// File: rtl/prog_shift_delay.sv
// prog_shift_delay: programmable circular-buffer delay line for NCH channels,
// delay counted in clocks (MODE 0) or in valid samples (MODE 1).
module prog_shift_delay #(
  parameter int MAX_LEN = 64,
  parameter int DW      = 16,
  parameter int NCH     = 2,
  parameter int MODE    = 0,
  parameter int DEF_DLY = 8,
  localparam int CW     = $clog2(MAX_LEN + 1),
  localparam int AW     = $clog2(MAX_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*DW-1:0]   d_in,
  input  logic                d_in_val,
  input  logic [CW-1:0]       cfg_dly,
  input  logic                cfg_load,
  output logic [NCH*DW-1:0]   d_out,
  output logic                d_out_val,
  output logic [CW-1:0]       cur_dly,
  output logic                filling,
  output logic                cfg_err
);
  typedef enum logic {FILL, RUN} state_t;
  localparam logic [CW-1:0] MAXC = CW'(MAX_LEN);
  state_t state_q, state_d;
  logic [NCH*DW:0] mem [MAX_LEN];
  logic [AW-1:0] wp_q, wp_d, rd;
  logic [CW-1:0] dly_q, dly_d, cnt_q, cnt_d, wpx, rdx;
  logic [NCH*DW-1:0] d_out_q, d_out_d;
  logic val_q, val_d, err_q, err_d, we, run;
  always_comb begin
    we      = MODE == 0 || d_in_val;
    run     = state_q == RUN && !cfg_load;
    wpx     = CW'(wp_q);
    rdx     = wpx >= dly_q ? wpx - dly_q : MAXC - (dly_q - wpx);
    rd      = rdx[AW-1:0];
    wp_d    = !we ? wp_q : wp_q == AW'(MAX_LEN - 1) ? '0 : wp_q + 1'b1;
    dly_d   = !cfg_load ? dly_q : cfg_dly == '0 ? CW'(1) : cfg_dly > MAXC ? MAXC : cfg_dly;
    err_d   = cfg_load && (cfg_dly == '0 || cfg_dly > MAXC);
    // a write coinciding with cfg_load is fill write 1 of the new delay
    cnt_d   = cfg_load ? CW'(we) : we && cnt_q < dly_q ? cnt_q + 1'b1 : cnt_q;
    state_d = cnt_d >= dly_d ? RUN : FILL;
    d_out_d = !run ? '0 : (MODE == 0 || d_in_val) ? mem[rd][NCH*DW-1:0] : d_out_q;
    val_d   = run && (MODE == 0 ? mem[rd][NCH*DW] : d_in_val);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FILL;
      wp_q    <= '0;
      dly_q   <= CW'(DEF_DLY);
      cnt_q   <= '0;
      d_out_q <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  // read above is combinational, so D=MAX_LEN sees the entry before this overwrite
  always_ff @(posedge clk)
    if (we) mem[wp_q] <= {d_in_val, d_in};
  assign d_out     = d_out_q;
  assign d_out_val = val_q;
  assign cur_dly   = dly_q;
  assign filling   = state_q == FILL;
  assign cfg_err   = err_q;
endmodule

// File: tb/tb_prog_shift_delay.sv
// tb_prog_shift_delay: clock-mode (2ch) and sample-mode (1ch) instances checked
// every cycle against history/queue reference models.
module tb_prog_shift_delay;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] d_in0 = '0, d_out0;
  logic [15:0] d_in1 = '0, d_out1;
  logic val0 = 1'b0, load0 = 1'b0, oval0, fill0, err0;
  logic val1 = 1'b0, load1 = 1'b0, oval1, fill1, err1;
  logic [6:0] cfg0 = '0, cfg1 = '0, cur0, cur1;
  int checks = 0, failures = 0, n = 0, r0 = 1, d0 = 8, c1 = 0, k1 = 0, d1 = 4;
  logic [31:0] hist_d [int];
  logic hist_v [int];
  logic [15:0] q1 [$];
  logic [31:0] e_out0 = '0;
  logic [15:0] e_out1 = '0;
  logic e_val0 = 1'b0, e_val1 = 1'b0;

  prog_shift_delay #(.MAX_LEN(64), .DW(16), .NCH(2), .MODE(0), .DEF_DLY(8)) u0 (
    .clk(clk), .rst(rst), .d_in(d_in0), .d_in_val(val0), .cfg_dly(cfg0), .cfg_load(load0),
    .d_out(d_out0), .d_out_val(oval0), .cur_dly(cur0), .filling(fill0), .cfg_err(err0));
  prog_shift_delay #(.MAX_LEN(64), .DW(16), .NCH(1), .MODE(1), .DEF_DLY(4)) u1 (
    .clk(clk), .rst(rst), .d_in(d_in1), .d_in_val(val1), .cfg_dly(cfg1), .cfg_load(load1),
    .d_out(d_out1), .d_out_val(oval1), .cur_dly(cur1), .filling(fill1), .cfg_err(err1));

  function automatic int clampd(int v);
    return v == 0 ? 1 : v > 64 ? 64 : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_d_out0", d_out0, 32'd0);
    chk("rst_val0", 32'(oval0), 32'd0);
    chk("rst_fill0", 32'(fill0), 32'd1);
    chk("rst_cur0", 32'(cur0), 32'd8);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_d_out1", 32'(d_out1), 32'd0);
    chk("rst_val1", 32'(oval1), 32'd0);
    chk("rst_cur1", 32'(cur1), 32'd4);
  endtask

  task automatic model_reset();
    r0 = n + 1;
    d0 = 8;
    d1 = 4;
    q1.delete();
    e_out1 = '0;
    e_val1 = 1'b0;
  endtask

  task automatic tick();
    bit was_run;
    c1++;
    if (c1 <= 60) begin
      val1  = (c1 % 3 == 0);
      if (val1) k1++;
      d_in1 = 16'(10 * k1);
      load1 = 1'b0;
    end else begin
      val1  = $urandom_range(0, 2) != 0;
      d_in1 = 16'($urandom);
      load1 = $urandom_range(0, 49) == 0;
      cfg1  = 7'($urandom_range(0, 70));
    end
    @(posedge clk);
    n++;
    hist_d[n] = d_in0;
    hist_v[n] = val0;
    if (load0) begin
      d0 = clampd(int'(cfg0));
      r0 = n;
    end
    e_out0 = (n - r0 >= d0) ? hist_d[n - d0] : '0;
    e_val0 = (n - r0 >= d0) ? hist_v[n - d0] : 1'b0;
    if (load1) begin
      d1 = clampd(int'(cfg1));
      q1.delete();
      e_out1 = '0;
      e_val1 = 1'b0;
      if (val1) q1.push_back(d_in1);
    end else if (val1) begin
      was_run = q1.size() >= d1;
      q1.push_back(d_in1);
      e_out1 = was_run ? q1[q1.size() - 1 - d1] : '0;
      e_val1 = was_run;
    end else e_val1 = 1'b0;
    #1;
    chk("d_out0", d_out0, e_out0);
    chk("d_out_val0", 32'(oval0), 32'(e_val0));
    chk("filling0", 32'(fill0), 32'((n - r0 + 1) < d0));
    chk("cur_dly0", 32'(cur0), 32'(d0));
    chk("cfg_err0", 32'(err0), 32'(load0 && (cfg0 == 0 || cfg0 > 64)));
    chk("d_out1", 32'(d_out1), 32'(e_out1));
    chk("d_out_val1", 32'(oval1), 32'(e_val1));
    chk("filling1", 32'(fill1), 32'(q1.size() < d1));
    chk("cur_dly1", 32'(cur1), 32'(d1));
    chk("cfg_err1", 32'(err1), 32'(load1 && (cfg1 == 0 || cfg1 > 64)));
  endtask

  task automatic ramp(int cnt);
    for (int i = 1; i <= cnt; i++) begin
      d_in0 = {16'(1000 + i), 16'(i)};
      val0  = 1'b1;
      tick();
    end
  endtask

  task automatic rnd(int cnt);
    for (int i = 0; i < cnt; i++) begin
      d_in0 = $urandom;
      val0  = $urandom_range(0, 3) != 0;
      tick();
    end
  endtask

  task automatic load(int v);
    cfg0  = 7'(v);
    load0 = 1'b1;
    d_in0 = $urandom;
    val0  = 1'b1;
    tick();
    load0 = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    model_reset();
    ramp(30);
    load(3);
    rnd(20);
    load(0);
    rnd(10);
    load(65);
    rnd(150);
    load(64);
    rnd(3);
    load(64);
    rnd(70);
    load(5);
    rnd(2);
    load(2);
    rnd(10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ramp(20);
    rnd(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
